// File: rtl/calc4_defs.sv
// Shared key codes, FSM state encoding and datapath width for the 4-bit calculator.
package calc4_defs;

    localparam int WIDTH = 4;

    typedef enum logic [2:0] {
        KEY_DIGIT = 3'd0,
        KEY_ADD   = 3'd1,
        KEY_SUB   = 3'd2,
        KEY_EQ    = 3'd3,
        KEY_CLR   = 3'd4
    } key_t;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_CALC = 2'd2,
        S_RES  = 2'd3
    } state_t;

endpackage

// File: rtl/addsub4.sv
// Combinational 4-bit adder/subtractor; wraps modulo 2^4, no carry/borrow out.
module addsub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sel,
    output logic [3:0] y
);

    assign y = sel ? (a - b) : (a + b);

endmodule

// File: rtl/calc4.sv
// Calculator top: key controller wired to the addsub4 arithmetic block.
module calc4
    import calc4_defs::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [2:0]       key_type,
    input  logic [WIDTH-1:0] key_data,
    output logic [WIDTH-1:0] disp,
    output logic             result_valid,
    output logic [1:0]       state
);

    logic [WIDTH-1:0] op_a, op_b, op_y;
    logic             op_sel;

    calc4_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_type     (key_type),
        .key_data     (key_data),
        .a            (op_a),
        .b            (op_b),
        .sel          (op_sel),
        .y            (op_y),
        .disp         (disp),
        .result_valid (result_valid),
        .state        (state)
    );

    addsub4 u_addsub (
        .a   (op_a),
        .b   (op_b),
        .sel (op_sel),
        .y   (op_y)
    );

endmodule

// File: rtl/calc4_ctrl.sv
// Operand/operation controller feeding addsub4; latches its result into an accumulator.
//   state  | meaning
//   S_A    | entering operand A
//   S_B    | entering operand B
//   S_CALC | one-cycle compute, keys blocked
//   S_RES  | result shown, ready to chain
module calc4_ctrl
    import calc4_defs::*;
#(
    parameter int WIDTH = calc4_defs::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [2:0]       key_type,
    input  logic [WIDTH-1:0] key_data,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             sel,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] disp,
    output logic             result_valid,
    output logic [1:0]       state
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             sel_q, sel_d;
    logic             rv_q, rv_d;
    logic             key_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sel_q   <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sel_q   <= sel_d;
            rv_q    <= rv_d;
        end
    end

    assign key_acc = key_valid && key_ready;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sel_d   = sel_q;
        rv_d    = 1'b0;
        if (state_q == S_CALC) begin
            // Result becomes the next A so a following operator chains from it.
            acc_d   = y;
            a_d     = y;
            rv_d    = 1'b1;
            state_d = S_RES;
        end else if (key_acc) begin
            case (key_type)
                KEY_CLR: begin
                    state_d = S_A;
                    a_d     = '0;
                    b_d     = '0;
                    acc_d   = '0;
                    sel_d   = 1'b0;
                end
                KEY_DIGIT: begin
                    if (state_q == S_B) begin
                        b_d = key_data;
                    end else begin
                        a_d     = key_data;
                        state_d = S_A;
                    end
                end
                KEY_ADD, KEY_SUB: begin
                    sel_d = (key_type == KEY_SUB);
                    if (state_q != S_B) b_d = '0;
                    state_d = S_B;
                end
                KEY_EQ: begin
                    if (state_q == S_B || state_q == S_RES) state_d = S_CALC;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        key_ready = (state_q != S_CALC);
        case (state_q)
            S_B:     disp = b_q;
            S_RES:   disp = acc_q;
            default: disp = a_q;
        endcase
    end

    assign a            = a_q;
    assign b            = b_q;
    assign sel          = sel_q;
    assign result_valid = rv_q;
    assign state        = state_q;

endmodule

// File: tb/tb_calc4_ctrl.sv
// Directed bench for calc4_ctrl with a behavioural add/sub closing the y loop.
module tb_calc4_ctrl;

    localparam logic [2:0] K_DIG = 3'd0;
    localparam logic [2:0] K_ADD = 3'd1;
    localparam logic [2:0] K_SUB = 3'd2;
    localparam logic [2:0] K_EQ  = 3'd3;
    localparam logic [2:0] K_CLR = 3'd4;
    localparam int ST_A = 0, ST_B = 1, ST_CALC = 2, ST_RES = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic       key_ready;
    logic [2:0] key_type = 3'd0;
    logic [3:0] key_data = 4'd0;
    logic [3:0] a, b, y, disp;
    logic       sel, result_valid;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign y = sel ? (a - b) : (a + b);

    calc4_ctrl #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_type     (key_type),
        .key_data     (key_data),
        .a            (a),
        .b            (b),
        .sel          (sel),
        .y            (y),
        .disp         (disp),
        .result_valid (result_valid),
        .state        (state)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [2:0] t, input logic [3:0] d);
        key_valid = 1'b1;
        key_type  = t;
        key_data  = d;
        step();
        key_valid = 1'b0;
    endtask

    initial begin
        #1;
        step();
        step();
        rst = 1'b0;
        chk("rst_state", state, ST_A);
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_sel", sel, 0);
        chk("rst_disp", disp, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_ready", key_ready, 1);

        // 5 + 3
        press(K_DIG, 4'd5);
        chk("t1_a", a, 5);
        chk("t1_dispA", disp, 5);
        press(K_EQ, 4'd0);
        chk("t1_eq_ignored", state, ST_A);
        press(3'd7, 4'd9);
        chk("t1_undef_a", a, 5);
        chk("t1_undef_state", state, ST_A);
        press(K_ADD, 4'd0);
        chk("t1_stB", state, ST_B);
        chk("t1_dispB0", disp, 0);
        press(K_DIG, 4'd3);
        chk("t1_dispB", disp, 3);
        press(K_EQ, 4'd0);
        chk("t1_calc", state, ST_CALC);
        chk("t1_calc_ready", key_ready, 0);
        chk("t1_calc_rv", result_valid, 0);
        step();
        chk("t1_res", state, ST_RES);
        chk("t1_rv", result_valid, 1);
        chk("t1_acc", disp, 8);
        chk("t1_chain_a", a, 8);
        step();
        chk("t1_rv_pulse", result_valid, 0);
        chk("t1_hold", disp, 8);

        // chaining and repeat-equals: 8+9=1, +9=10, +9=3
        press(K_ADD, 4'd0);
        chk("t3_stB", state, ST_B);
        chk("t3_b_clr", b, 0);
        press(K_DIG, 4'd9);
        press(K_EQ, 4'd0);
        step();
        chk("t3_acc1", disp, 1);
        press(K_EQ, 4'd0);
        chk("t3_rep_calc", state, ST_CALC);
        step();
        chk("t3_acc2", disp, 10);
        chk("t3_rv2", result_valid, 1);
        press(K_EQ, 4'd0);
        step();
        chk("t3_acc3", disp, 3);

        // 3 - 5 wraps to 14
        press(K_DIG, 4'd3);
        chk("t2_newA", state, ST_A);
        chk("t2_a", a, 3);
        press(K_SUB, 4'd0);
        press(K_DIG, 4'd5);
        press(K_EQ, 4'd0);
        chk("t2_sel", sel, 1);
        step();
        chk("t2_acc", disp, 14);

        // key held through S_CALC: 14 - 5 = 9, then DIGIT 7 taken in S_RES
        press(K_EQ, 4'd0);
        key_valid = 1'b1;
        key_type  = K_DIG;
        key_data  = 4'd7;
        chk("t4_calc_ready", key_ready, 0);
        step();
        chk("t4_res", state, ST_RES);
        chk("t4_acc", disp, 9);
        chk("t4_res_ready", key_ready, 1);
        step();
        key_valid = 1'b0;
        chk("t4_stA", state, ST_A);
        chk("t4_a", a, 7);
        chk("t4_disp", disp, 7);

        // operator change in S_B: last one wins, 6 - 2 = 4
        press(K_DIG, 4'd6);
        press(K_ADD, 4'd0);
        press(K_SUB, 4'd0);
        chk("t5_stB", state, ST_B);
        chk("t5_sel", sel, 1);
        press(K_DIG, 4'd2);
        press(K_EQ, 4'd0);
        step();
        chk("t5_acc", disp, 4);

        // reset during S_CALC
        press(K_DIG, 4'd5);
        press(K_ADD, 4'd0);
        press(K_DIG, 4'd3);
        press(K_EQ, 4'd0);
        chk("t6_calc", state, ST_CALC);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_state", state, ST_A);
        chk("t6_a", a, 0);
        chk("t6_b", b, 0);
        chk("t6_sel", sel, 0);
        chk("t6_disp", disp, 0);
        chk("t6_rv", result_valid, 0);
        step();
        chk("t6_rv_late", result_valid, 0);
        chk("t6_state_late", state, ST_A);

        // KEY_CLR from S_B
        press(K_DIG, 4'd5);
        press(K_SUB, 4'd0);
        press(K_DIG, 4'd3);
        press(K_CLR, 4'd0);
        chk("t7_state", state, ST_A);
        chk("t7_a", a, 0);
        chk("t7_b", b, 0);
        chk("t7_sel", sel, 0);
        chk("t7_disp", disp, 0);
        chk("t7_rv", result_valid, 0);

        // rst wins over a simultaneous key
        press(K_DIG, 4'd4);
        rst = 1'b1;
        press(K_DIG, 4'd9);
        rst = 1'b0;
        chk("t8_rst_wins", a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
